// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control unit: FSM state encoding,
// opcodes, datapath select/function constants, the control bundle type and
// the register-code to active-low RegSel mapping.
package control_pkg;

  typedef enum logic [1:0] {
    StFetchHi = 2'd0,
    StFetchLo = 2'd1,
    StExec    = 2'd2,
    StHalt    = 2'd3
  } state_e;

  localparam logic [3:0] OpAnd  = 4'h0;
  localparam logic [3:0] OpOr   = 4'h1;
  localparam logic [3:0] OpNot  = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpLsr  = 4'h5;
  localparam logic [3:0] OpLsl  = 4'h6;
  localparam logic [3:0] OpInc  = 4'h7;
  localparam logic [3:0] OpLd   = 4'h8;
  localparam logic [3:0] OpBra  = 4'h9;
  localparam logic [3:0] OpBne  = 4'hA;
  localparam logic [3:0] OpMov  = 4'hB;
  localparam logic [3:0] OpLdi  = 4'hC;
  localparam logic [3:0] OpLdar = 4'hD;
  localparam logic [3:0] OpSt   = 4'hE;
  localparam logic [3:0] OpHlt  = 4'hF;

  localparam logic [3:0] AluPassA = 4'h0;
  localparam logic [3:0] AluNot   = 4'h2;
  localparam logic [3:0] AluAdd   = 4'h4;
  localparam logic [3:0] AluSub   = 4'h6;
  localparam logic [3:0] AluAnd   = 4'h7;
  localparam logic [3:0] AluOr    = 4'h8;
  localparam logic [3:0] AluLsl   = 4'hA;
  localparam logic [3:0] AluLsr   = 4'hB;

  // FunSel shared by RF, ARF and IR
  localparam logic [1:0] FunDec   = 2'd0;
  localparam logic [1:0] FunInc   = 2'd1;
  localparam logic [1:0] FunLoad  = 2'd2;
  localparam logic [1:0] FunClear = 2'd3;

  localparam logic [1:0] MuxAImm  = 2'd0;
  localparam logic [1:0] MuxAMem  = 2'd1;
  localparam logic [1:0] MuxAAlu  = 2'd3;
  localparam logic [1:0] MuxBImm  = 2'd1;
  localparam logic [1:0] ArfOutPc = 2'd0;
  localparam logic [1:0] ArfOutAr = 2'd2;

  localparam logic [2:0] ArfSelNone = 3'b111;
  localparam logic [2:0] ArfSelPc   = 3'b011;
  localparam logic [2:0] ArfSelAr   = 3'b101;
  localparam logic [3:0] RfSelNone  = 4'b1111;

  typedef struct packed {
    logic [1:0] rf_outa_sel;
    logic [1:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // Every cycle starts from this bundle: nothing enabled, memory deselected.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c              = '0;
    c.rf_fun_sel   = FunLoad;
    c.rf_reg_sel   = RfSelNone;
    c.arf_fun_sel  = FunLoad;
    c.arf_reg_sel  = ArfSelNone;
    c.ir_funsel    = FunLoad;
    c.mem_cs       = 1'b1;
    return c;
  endfunction

  // Register code to active-low enable, R1 on bit 3 down to R4 on bit 0
  function automatic logic [3:0] rf_sel(input logic [1:0] rr);
    logic [3:0] sel;
    case (rr)
      2'b00:   sel = 4'b0111;
      2'b01:   sel = 4'b1011;
      2'b10:   sel = 4'b1101;
      default: sel = 4'b1110;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational EXEC-cycle decoder.
// Ports:
//   ir    - current instruction register contents
//   flags - ALU flags {Z,C,N,O}; only Z is consumed (BNE)
//   ctrl  - datapath control bundle for the execute cycle
//   halt  - instruction is HLT; FSM moves to HALT
module control_decode
  import control_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output ctrl_t       ctrl,
  output logic        halt
);

  logic [3:0] opcode;
  logic [1:0] rd, rs1, rs2;
  logic       unused_bits;

  assign opcode = ir[15:12];
  assign rd     = ir[11:10];
  assign rs1    = ir[9:8];
  assign rs2    = ir[7:6];

  // Immediate bits go straight from IR to the datapath, C/N/O are not needed here
  assign unused_bits = ^{ir[5:0], flags[2:0]};

  always_comb begin
    ctrl = ctrl_idle();
    halt = 1'b0;
    unique case (opcode)
      OpAnd, OpOr, OpNot, OpAdd, OpSub, OpLsr, OpLsl: begin
        ctrl.rf_outa_sel = rs1;
        ctrl.rf_outb_sel = rs2;
        ctrl.mux_c_sel   = 1'b1;
        ctrl.mux_a_sel   = MuxAAlu;
        ctrl.rf_fun_sel  = FunLoad;
        ctrl.rf_reg_sel  = rf_sel(rd);
        case (opcode)
          OpAnd:   ctrl.alu_fun_sel = AluAnd;
          OpOr:    ctrl.alu_fun_sel = AluOr;
          OpNot:   ctrl.alu_fun_sel = AluNot;
          OpAdd:   ctrl.alu_fun_sel = AluAdd;
          OpSub:   ctrl.alu_fun_sel = AluSub;
          OpLsr:   ctrl.alu_fun_sel = AluLsr;
          default: ctrl.alu_fun_sel = AluLsl;
        endcase
      end
      OpInc: begin
        ctrl.rf_fun_sel = FunInc;
        ctrl.rf_reg_sel = rf_sel(rd);
      end
      OpLd: begin
        ctrl.mem_cs       = 1'b0;
        ctrl.arf_outd_sel = ArfOutAr;
        ctrl.mux_a_sel    = MuxAMem;
        ctrl.rf_fun_sel   = FunLoad;
        ctrl.rf_reg_sel   = rf_sel(rd);
      end
      OpBra, OpBne: begin
        // BNE falls back to idle when Z is set
        if (opcode == OpBra || !flags[3]) begin
          ctrl.mux_b_sel   = MuxBImm;
          ctrl.arf_fun_sel = FunLoad;
          ctrl.arf_reg_sel = ArfSelPc;
        end
      end
      OpMov: begin
        ctrl.rf_outa_sel = rs1;
        ctrl.alu_fun_sel = AluPassA;
        ctrl.mux_c_sel   = 1'b1;
        ctrl.mux_a_sel   = MuxAAlu;
        ctrl.rf_fun_sel  = FunLoad;
        ctrl.rf_reg_sel  = rf_sel(rd);
      end
      OpLdi: begin
        ctrl.mux_a_sel  = MuxAImm;
        ctrl.rf_fun_sel = FunLoad;
        ctrl.rf_reg_sel = rf_sel(rd);
      end
      OpLdar: begin
        ctrl.mux_b_sel   = MuxBImm;
        ctrl.arf_fun_sel = FunLoad;
        ctrl.arf_reg_sel = ArfSelAr;
      end
      OpSt: begin
        ctrl.rf_outa_sel  = rd;
        ctrl.mux_c_sel    = 1'b1;
        ctrl.alu_fun_sel  = AluPassA;
        ctrl.arf_outd_sel = ArfOutAr;
        ctrl.mem_cs       = 1'b0;
        ctrl.mem_wr       = 1'b1;
      end
      OpHlt: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the 8-bit datapath: two fetch cycles (high then
// low IR byte, PC++ each), one execute cycle, and a sticky HALT state.
// Ports:
//   Clock, Reset      - rising-edge clock, synchronous active-high reset
//   IROut, Flags      - instruction register and ALU flags from the datapath
//   RF_* / ARF_* / IR_* / Mem_* / Mux*Sel / ALU_FunSel - datapath controls
//   Halted, State     - HALT indicator and debug copy of the FSM state
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [1:0]  State
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;
  logic   dec_halt;

  control_decode u_decode (
    .ir    (IROut),
    .flags (Flags),
    .ctrl  (dec_ctrl),
    .halt  (dec_halt)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StFetchHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetchHi: state_d = StFetchLo;
      StFetchLo: state_d = StExec;
      StExec:    state_d = dec_halt ? StHalt : StFetchHi;
      StHalt:    state_d = StHalt;
    endcase
  end

  always_comb begin
    ctrl   = ctrl_idle();
    Halted = 1'b0;
    if (Reset) begin
      // Clear PC on the same edge that restarts the FSM
      ctrl.arf_reg_sel = ArfSelPc;
      ctrl.arf_fun_sel = FunClear;
    end else begin
      unique case (state_q)
        StFetchHi, StFetchLo: begin
          ctrl.mem_cs       = 1'b0;
          ctrl.arf_outd_sel = ArfOutPc;
          ctrl.ir_enable    = 1'b1;
          ctrl.ir_funsel    = FunLoad;
          ctrl.ir_lh        = (state_q == StFetchLo);
          ctrl.arf_reg_sel  = ArfSelPc;
          ctrl.arf_fun_sel  = FunInc;
        end
        StExec: ctrl = dec_ctrl;
        StHalt: Halted = 1'b1;
      endcase
    end
  end

  assign RF_OutASel  = ctrl.rf_outa_sel;
  assign RF_OutBSel  = ctrl.rf_outb_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RegSel   = ctrl.rf_reg_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutCSel = ctrl.arf_outc_sel;
  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign State       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of EXEC-cycle decode vectors
// plus directed sequences for reset, fetch, HALT and reset mid-fetch.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [1:0]  State;

  control_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IROut       (IROut),
    .Flags       (Flags),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .RF_FunSel   (RF_FunSel),
    .RF_RegSel   (RF_RegSel),
    .ALU_FunSel  (ALU_FunSel),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RegSel  (ARF_RegSel),
    .IR_LH       (IR_LH),
    .IR_Enable   (IR_Enable),
    .IR_Funsel   (IR_Funsel),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .Halted      (Halted),
    .State       (State)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic [1:0] state;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [3:0]  flags;
    obs_t        exp;
    logic [1:0]  next;
  } vec_t;

  obs_t got;
  assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted, State};

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  function automatic obs_t idle_obs(input logic [1:0] st);
    obs_t o;
    o         = '0;
    o.rf_fun  = 2'd2;
    o.rf_reg  = 4'hF;
    o.arf_fun = 2'd2;
    o.arf_reg = 3'b111;
    o.ir_fun  = 2'd2;
    o.mem_cs  = 1'b1;
    o.state   = st;
    return o;
  endfunction

  function automatic obs_t fetch_obs(input logic lo);
    obs_t o;
    o         = idle_obs({1'b0, lo});
    o.mem_cs  = 1'b0;
    o.outd    = 2'd0;
    o.ir_en   = 1'b1;
    o.ir_fun  = 2'd2;
    o.ir_lh   = lo;
    o.arf_reg = 3'b011;
    o.arf_fun = 2'd1;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [3:0] actual, input logic [3:0] exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [15:0] ir, input logic [3:0] fl,
                         input obs_t e, input logic [1:0] nx);
    vec_t v;
    v.name  = n;
    v.ir    = ir;
    v.flags = fl;
    v.exp   = e;
    v.next  = nx;
    vecs.push_back(v);
  endtask

  // Restart from reset and walk through both fetch cycles into EXEC
  task automatic to_exec(input logic [15:0] ir, input logic [3:0] fl);
    IROut = ir;
    Flags = fl;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    step();
    step();
  endtask

  initial begin
    obs_t e;
    Reset = 1'b1;
    IROut = 16'h0000;
    Flags = 4'h0;

    // Table of EXEC vectors; expected bundles written out by hand
    e = idle_obs(2); e.alu = 4'h4; e.outa = 2'd1; e.outb = 2'd2; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b0111; add_vec("ADD", 16'h31B0, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'h7; e.outa = 2'd2; e.outb = 2'd1; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1110; add_vec("AND", 16'h0E40, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'h8; e.outa = 2'd1; e.outb = 2'd0; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1011; add_vec("OR", 16'h1500, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'h2; e.outa = 2'd2; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1101; add_vec("NOT", 16'h2A00, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'h6; e.outa = 2'd3; e.outb = 2'd3; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1011; add_vec("SUB", 16'h47C0, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'hB; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1110; add_vec("LSR", 16'h5C00, 4'h0, e, 2'd0);
    e = idle_obs(2); e.alu = 4'hA; e.outa = 2'd1; e.mux_c = 1; e.mux_a = 2'd3;
    e.rf_reg = 4'b1101; add_vec("LSL", 16'h6900, 4'h0, e, 2'd0);
    e = idle_obs(2); e.rf_fun = 2'd1; e.rf_reg = 4'b1011; add_vec("INC", 16'h7400, 4'h0, e, 2'd0);
    e = idle_obs(2); e.mem_cs = 0; e.outd = 2'd2; e.mux_a = 2'd1; e.rf_reg = 4'b1110;
    add_vec("LD", 16'h8C00, 4'h0, e, 2'd0);
    e = idle_obs(2); e.mux_b = 2'd1; e.arf_fun = 2'd2; e.arf_reg = 3'b011;
    add_vec("BRA", 16'h9042, 4'h8, e, 2'd0);
    add_vec("BNE_taken", 16'hA040, 4'h0, e, 2'd0);
    add_vec("BNE_taken_cno", 16'hA040, 4'h7, e, 2'd0);
    e = idle_obs(2); add_vec("BNE_not_taken", 16'hA040, 4'h8, e, 2'd0);
    e = idle_obs(2); e.outa = 2'd1; e.mux_c = 1; e.mux_a = 2'd3; e.rf_reg = 4'b1101;
    add_vec("MOV", 16'hB900, 4'h0, e, 2'd0);
    e = idle_obs(2); e.mux_a = 2'd0; e.rf_reg = 4'b1011; add_vec("LDI", 16'hC455, 4'h0, e, 2'd0);
    e = idle_obs(2); e.mux_b = 2'd1; e.arf_fun = 2'd2; e.arf_reg = 3'b101;
    add_vec("LDAR", 16'hD080, 4'h0, e, 2'd0);
    e = idle_obs(2); e.outa = 2'd2; e.mux_c = 1; e.outd = 2'd2; e.mem_cs = 0; e.mem_wr = 1;
    add_vec("ST", 16'hE800, 4'h0, e, 2'd0);
    e = idle_obs(2); add_vec("HLT", 16'hF000, 4'h0, e, 2'd3);

    // Reset held two cycles, then released into fetch
    step();
    e = idle_obs(0); e.arf_reg = 3'b011; e.arf_fun = 2'd3;
    check_obs("reset_vector", e);
    step();
    check_obs("reset_vector_2", e);
    Reset = 1'b0;
    #1;
    check_obs("fetch_hi", fetch_obs(1'b0));
    step();
    check_obs("fetch_lo", fetch_obs(1'b1));
    step();
    check_val("exec_state", {2'b0, State}, 4'd2);

    foreach (vecs[i]) begin
      to_exec(vecs[i].ir, vecs[i].flags);
      check_obs(vecs[i].name, vecs[i].exp);
      step();
      check_val({vecs[i].name, "_next"}, {2'b0, State}, {2'b0, vecs[i].next});
    end

    // HLT is sticky for many cycles and leaves only through Reset
    to_exec(16'hF000, 4'h0);
    step();
    check_obs("halt_entry", {idle_obs(3)} | obs_t'(4'b0100));
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("halt_hold", {State, Halted, Mem_CS}, 4'b1111);
    end
    Reset = 1'b1;
    #1;
    check_val("halt_reset_halted", {3'b0, Halted}, 4'd0);
    step();
    check_val("halt_reset_state", {2'b0, State}, 4'd0);
    Reset = 1'b0;
    #1;
    check_obs("halt_reset_fetch", fetch_obs(1'b0));

    // Reset asserted mid-fetch: no IR load, PC clear, restart at FETCH_HI
    step();
    check_val("mid_state", {2'b0, State}, 4'd1);
    Reset = 1'b1;
    #1;
    check_val("mid_ir_enable", {3'b0, IR_Enable}, 4'd0);
    check_val("mid_pc_clear", {ARF_RegSel, 1'b0}, 4'b0110);
    check_val("mid_arf_fun", {2'b0, ARF_FunSel}, 4'd3);
    step();
    Reset = 1'b0;
    #1;
    check_obs("mid_refetch", fetch_obs(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
